uart_cmd_ctrl: RTL and testbench

Frame controller that sits directly behind uart_rx. It consumes received bytes through uart_rx's done/byte-accept handshake and parses fixed 5-byte command frames: SYNC, CMD, ADDR, DATA, CHK. Each good frame is presented as a write or read command on a valid/ready interface to the register-file side. It detects framing, checksum, bad-command and inter-byte-timeout errors and keeps a saturating error count.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_timeout_timer.sv | 29 ++
 rtl/uart_cmd_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and bit-timing helper for the UART
// receive path and the command-frame controller behind it.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] CMD_RD    = 8'h52;

  localparam logic [1:0] ERR_FRAMING  = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_BADCMD   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CHK  = 3'd4,
    S_OUT  = 3'd5
  } state_t;

  // Integer clock cycles per serial bit; truncation matches uart_rx.
  function automatic int cycles_per_bit(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte watchdog: counts while enabled, clears on demand, and flags the
// cycle in which the count reaches limit-1.
module uart_timeout_timer #(
  parameter int unsigned limit = 9360
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [15:0] LAST = 16'(limit - 1);

  logic [15:0] count_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (i_clear) begin
      count_q <= '0;
    end else if (i_enable) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign o_expire = i_enable && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/ADDR/DATA/CHK frames from uart_rx into register-file
// commands on a valid/ready port, reporting framing/checksum/cmd/timeout errors.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int          clk_frequency = 27,
  parameter int          baud_rate     = 115200,
  parameter int          timeout_bytes = 4,
  parameter logic [7:0]  sync_byte     = SYNC_BYTE
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_done,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_framing_error,
  output logic       o_byte_accept,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic       o_cmd_wr,
  output logic [7:0] o_cmd_addr,
  output logic [7:0] o_cmd_data,
  output logic       o_err,
  output logic [1:0] o_err_code,
  output logic [7:0] o_err_count,
  output logic [2:0] o_state
);

  localparam int timeout_cycles =
    timeout_bytes * 10 * cycles_per_bit(clk_frequency, baud_rate);

  // Handshakes: the byte side captures when i_rx_done is high, no accept
  // pulse is in flight and no command is pending; o_byte_accept pulses for
  // the following cycle. The command side transfers on any edge with
  // o_cmd_valid && i_cmd_ready; valid and fields stay stable until then.

  state_t     state_q, state_d;
  logic       accept_q;
  logic [7:0] chk_q, chk_d;
  logic       wr_q, wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       err_det_q, err_det_d;
  logic [1:0] err_det_code_q, err_det_code_d;
  logic       err_q;
  logic [1:0] err_code_q;
  logic [7:0] err_count_q;

  logic capture;
  logic in_frame;
  logic expire;

  assign capture  = i_rx_done && !accept_q && (state_q != S_OUT);
  assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                    (state_q == S_DATA) || (state_q == S_CHK);

  uart_timeout_timer #(
    .limit(timeout_cycles)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (capture || !in_frame || expire),
    .i_enable(in_frame),
    .o_expire(expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    chk_d          = chk_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    data_d         = data_q;
    err_det_d      = 1'b0;
    err_det_code_d = err_det_code_q;

    if (state_q == S_OUT) begin
      if (i_cmd_ready) begin
        state_d = S_SYNC;
      end
    end else if (capture) begin
      // A capture in the same cycle as expiry takes precedence.
      if (i_rx_framing_error) begin
        state_d        = S_SYNC;
        err_det_d      = 1'b1;
        err_det_code_d = ERR_FRAMING;
      end else begin
        case (state_q)
          S_SYNC: begin
            if (i_rx_byte == sync_byte) begin
              state_d = S_CMD;
              chk_d   = 8'h00;
            end
          end
          S_CMD: begin
            if ((i_rx_byte == CMD_WR) || (i_rx_byte == CMD_RD)) begin
              state_d = S_ADDR;
              wr_d    = (i_rx_byte == CMD_WR);
              chk_d   = chk_q ^ i_rx_byte;
            end else begin
              state_d        = S_SYNC;
              err_det_d      = 1'b1;
              err_det_code_d = ERR_BADCMD;
            end
          end
          S_ADDR: begin
            state_d = S_DATA;
            addr_d  = i_rx_byte;
            chk_d   = chk_q ^ i_rx_byte;
          end
          S_DATA: begin
            state_d = S_CHK;
            data_d  = i_rx_byte;
            chk_d   = chk_q ^ i_rx_byte;
          end
          S_CHK: begin
            if (i_rx_byte == chk_q) begin
              state_d = S_OUT;
            end else begin
              state_d        = S_SYNC;
              err_det_d      = 1'b1;
              err_det_code_d = ERR_CHECKSUM;
            end
          end
          default: state_d = S_SYNC;
        endcase
      end
    end else if (expire) begin
      state_d        = S_SYNC;
      err_det_d      = 1'b1;
      err_det_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      accept_q       <= 1'b0;
      chk_q          <= '0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      err_det_q      <= 1'b0;
      err_det_code_q <= '0;
      err_q          <= 1'b0;
      err_code_q     <= '0;
      err_count_q    <= '0;
    end else begin
      accept_q       <= capture;
      chk_q          <= chk_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      err_det_q      <= err_det_d;
      err_det_code_q <= err_det_code_d;
      err_q          <= err_det_q;
      if (err_det_q) begin
        err_code_q <= err_det_code_q;
        if (err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  assign o_byte_accept = accept_q;
  assign o_cmd_valid   = (state_q == S_OUT);
  assign o_cmd_wr      = wr_q;
  assign o_cmd_addr    = addr_q;
  assign o_cmd_data    = data_q;
  assign o_err         = err_q;
  assign o_err_code    = err_code_q;
  assign o_err_count   = err_count_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: feeds bytes through the done/accept
// handshake and scores decoded commands, error pulses and counters.
module tb_uart_cmd_ctrl;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_rx_done;
  logic [7:0] i_rx_byte;
  logic       i_rx_framing_error;
  logic       o_byte_accept;
  logic       o_cmd_valid;
  logic       i_cmd_ready;
  logic       o_cmd_wr;
  logic [7:0] o_cmd_addr;
  logic [7:0] o_cmd_data;
  logic       o_err;
  logic [1:0] o_err_code;
  logic [7:0] o_err_count;
  logic [2:0] o_state;

  int n_vec;
  int n_miss;

  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  logic [1:0]  err_q[$];
  int          acc_cnt;
  int          unstable;
  logic        pend_prev;
  logic [16:0] pend_fields;

  uart_cmd_ctrl dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_rx_done         (i_rx_done),
    .i_rx_byte         (i_rx_byte),
    .i_rx_framing_error(i_rx_framing_error),
    .o_byte_accept     (o_byte_accept),
    .o_cmd_valid       (o_cmd_valid),
    .i_cmd_ready       (i_cmd_ready),
    .o_cmd_wr          (o_cmd_wr),
    .o_cmd_addr        (o_cmd_addr),
    .o_cmd_data        (o_cmd_data),
    .o_err             (o_err),
    .o_err_code        (o_err_code),
    .o_err_count       (o_err_count),
    .o_state           (o_state)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor on the falling edge, away from the active edge.
  initial begin
    acc_cnt     = 0;
    unstable    = 0;
    pend_prev   = 1'b0;
    pend_fields = '0;
  end

  always @(negedge i_clk) begin
    if (o_byte_accept) acc_cnt++;
    if (o_err) err_q.push_back(o_err_code);
    if (o_cmd_valid && i_cmd_ready) got_q.push_back({o_cmd_wr, o_cmd_addr, o_cmd_data});
    if (pend_prev && o_cmd_valid && ({o_cmd_wr, o_cmd_addr, o_cmd_data} != pend_fields))
      unstable++;
    pend_prev   = o_cmd_valid && !i_cmd_ready;
    pend_fields = {o_cmd_wr, o_cmd_addr, o_cmd_data};
  end

  // Driver tasks
  task automatic clear_mon();
    exp_q.delete();
    got_q.delete();
    err_q.delete();
    acc_cnt  = 0;
    unstable = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    int t;
    t = 0;
    i_rx_byte          = b;
    i_rx_framing_error = fe;
    i_rx_done          = 1'b1;
    do begin
      @(posedge i_clk); #1;
      t++;
    end while (!o_byte_accept && t < 6000);
    n_vec++;
    if (!o_byte_accept) begin
      $display("FAIL accept_wait byte=%02h got no accept after %0d cycles, required accept", b, t);
      n_miss++;
    end
    @(posedge i_clk); #1;
    i_rx_done          = 1'b0;
    i_rx_framing_error = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5, 1'b0);
    send_byte(c, 1'b0);
    send_byte(a, 1'b0);
    send_byte(d, 1'b0);
    send_byte(k, 1'b0);
  endtask

  // Tests
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_rx_done = 1'b0;
    i_rx_byte = 8'h00;
    i_rx_framing_error = 1'b0;
    i_cmd_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    n_vec++;
    if ({o_byte_accept, o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_data, o_err, o_err_code} !== 21'd0) begin
      $display("FAIL reset_outputs got=%h required=0",
               {o_byte_accept, o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_data, o_err, o_err_code});
      n_miss++;
    end
    n_vec++;
    if (o_err_count !== 8'd0 || o_state !== 3'd0) begin
      $display("FAIL reset_count_state got count=%0d state=%0d required 0/0", o_err_count, o_state);
      n_miss++;
    end
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic test_write_frame();
    clear_mon();
    i_cmd_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h10, 8'h3C});
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      $display("FAIL write_cmd_count got=%0d required=%0d", got_q.size(), exp_q.size());
      n_miss++;
    end
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        $display("FAIL write_cmd[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : 17'h0, exp_q[i]);
        n_miss++;
      end
    end
    n_vec++;
    if (err_q.size() != 0) begin
      $display("FAIL write_no_err got=%0d pulses required=0", err_q.size());
      n_miss++;
    end
    n_vec++;
    if (acc_cnt != 5) begin
      $display("FAIL write_accepts got=%0d required=5", acc_cnt);
      n_miss++;
    end
  endtask

  task automatic test_garbage_read();
    clear_mon();
    exp_q.push_back({1'b0, 8'h20, 8'h00});
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_frame(8'h52, 8'h20, 8'h00, 8'h72);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      $display("FAIL garbage_read_cmd got_n=%0d got=%h required=%h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 17'h0, exp_q[0]);
      n_miss++;
    end
    n_vec++;
    if (err_q.size() != 0 || o_err_count !== 8'd0) begin
      $display("FAIL garbage_no_err got pulses=%0d count=%0d required 0/0", err_q.size(), o_err_count);
      n_miss++;
    end
    n_vec++;
    if (acc_cnt != 7) begin
      $display("FAIL garbage_accepts got=%0d required=7", acc_cnt);
      n_miss++;
    end
  endtask

  task automatic test_bad_checksum();
    clear_mon();
    send_frame(8'h57, 8'h10, 8'h3C, 8'h00);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (got_q.size() != 0) begin
      $display("FAIL badchk_no_cmd got=%0d required=0", got_q.size());
      n_miss++;
    end
    n_vec++;
    if (err_q.size() != 1 || err_q[0] !== 2'd1) begin
      $display("FAIL badchk_err got_n=%0d code=%0d required 1 pulse code 1", err_q.size(),
               (err_q.size() > 0) ? err_q[0] : 2'd0);
      n_miss++;
    end
    n_vec++;
    if (o_err_count !== 8'd1) begin
      $display("FAIL badchk_count got=%0d required=1", o_err_count);
      n_miss++;
    end
    exp_q.push_back({1'b1, 8'h10, 8'h3C});
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      $display("FAIL badchk_recover got_n=%0d required one cmd %h", got_q.size(), exp_q[0]);
      n_miss++;
    end
  endtask

  task automatic test_bad_cmd();
    clear_mon();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h41, 1'b0);
    exp_q.push_back({1'b1, 8'h01, 8'h02});
    send_frame(8'h57, 8'h01, 8'h02, 8'h54);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (err_q.size() != 1 || err_q[0] !== 2'd2) begin
      $display("FAIL badcmd_err got_n=%0d code=%0d required 1 pulse code 2", err_q.size(),
               (err_q.size() > 0) ? err_q[0] : 2'd0);
      n_miss++;
    end
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      $display("FAIL badcmd_recover got_n=%0d got=%h required=%h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 17'h0, exp_q[0]);
      n_miss++;
    end
    n_vec++;
    if (o_err_count !== 8'd2) begin
      $display("FAIL badcmd_count got=%0d required=2", o_err_count);
      n_miss++;
    end
  endtask

  task automatic test_timeout();
    int t;
    clear_mon();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h57, 1'b0);
    repeat (9000) @(posedge i_clk);
    #1;
    n_vec++;
    if (err_q.size() != 0) begin
      $display("FAIL timeout_early got=%0d pulses required=0 before 9360 cycles", err_q.size());
      n_miss++;
    end
    t = 0;
    while (err_q.size() == 0 && t < 1000) begin
      @(posedge i_clk); #1;
      t++;
    end
    repeat (50) @(posedge i_clk);
    #1;
    n_vec++;
    if (err_q.size() != 1 || err_q[0] !== 2'd3) begin
      $display("FAIL timeout_err got_n=%0d code=%0d required 1 pulse code 3", err_q.size(),
               (err_q.size() > 0) ? err_q[0] : 2'd0);
      n_miss++;
    end
    n_vec++;
    if (o_state !== 3'd0 || o_err_count !== 8'd3) begin
      $display("FAIL timeout_state got state=%0d count=%0d required 0/3", o_state, o_err_count);
      n_miss++;
    end
    exp_q.push_back({1'b0, 8'h20, 8'h00});
    send_frame(8'h52, 8'h20, 8'h00, 8'h72);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      $display("FAIL timeout_recover got_n=%0d required one cmd %h", got_q.size(), exp_q[0]);
      n_miss++;
    end
  endtask

  task automatic test_framing_error();
    clear_mon();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b1);
    send_byte(8'hA5, 1'b1);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (err_q.size() != 2 || err_q[0] !== 2'd0 || err_q[1] !== 2'd0) begin
      $display("FAIL framing_err got_n=%0d required 2 pulses code 0", err_q.size());
      n_miss++;
    end
    n_vec++;
    if (o_state !== 3'd0 || o_err_count !== 8'd5 || got_q.size() != 0) begin
      $display("FAIL framing_state got state=%0d count=%0d cmds=%0d required 0/5/0",
               o_state, o_err_count, got_q.size());
      n_miss++;
    end
  endtask

  task automatic test_back_to_back();
    int mark;
    clear_mon();
    i_cmd_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h10, 8'h3C});
    exp_q.push_back({1'b0, 8'h20, 8'h00});
    send_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    n_vec++;
    if (o_cmd_valid !== 1'b1 || {o_cmd_wr, o_cmd_addr, o_cmd_data} !== exp_q[0]) begin
      $display("FAIL b2b_pending got valid=%b fields=%h required 1/%h", o_cmd_valid,
               {o_cmd_wr, o_cmd_addr, o_cmd_data}, exp_q[0]);
      n_miss++;
    end
    mark = acc_cnt;
    fork
      send_frame(8'h52, 8'h20, 8'h00, 8'h72);
      begin
        repeat (3000) @(posedge i_clk);
        #1;
        n_vec++;
        if (acc_cnt != mark) begin
          $display("FAIL b2b_no_accept got=%0d extra accepts required=0", acc_cnt - mark);
          n_miss++;
        end
        n_vec++;
        if (o_cmd_valid !== 1'b1 || {o_cmd_wr, o_cmd_addr, o_cmd_data} !== exp_q[0] || unstable != 0) begin
          $display("FAIL b2b_hold got valid=%b fields=%h changes=%0d required 1/%h/0", o_cmd_valid,
                   {o_cmd_wr, o_cmd_addr, o_cmd_data}, unstable, exp_q[0]);
          n_miss++;
        end
        i_cmd_ready = 1'b1;
      end
    join
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (got_q.size() != 2) begin
      $display("FAIL b2b_count got=%0d required=2", got_q.size());
      n_miss++;
    end
    foreach (exp_q[i]) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        $display("FAIL b2b_cmd[%0d] got=%h required=%h", i, (i < got_q.size()) ? got_q[i] : 17'h0, exp_q[i]);
        n_miss++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h57, 1'b0);
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_vec++;
    if ({o_byte_accept, o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_data, o_err, o_err_code,
         o_err_count, o_state} !== 32'd0) begin
      $display("FAIL midreset_outputs got=%h required=0",
               {o_byte_accept, o_cmd_valid, o_cmd_wr, o_cmd_addr, o_cmd_data, o_err, o_err_code,
                o_err_count, o_state});
      n_miss++;
    end
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    exp_q.push_back({1'b0, 8'h20, 8'h00});
    send_frame(8'h52, 8'h20, 8'h00, 8'h72);
    repeat (5) @(posedge i_clk);
    #1;
    n_vec++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0] || err_q.size() != 0) begin
      $display("FAIL midreset_recover got_n=%0d errs=%0d required one cmd %h and 0 errs",
               got_q.size(), err_q.size(), exp_q[0]);
      n_miss++;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_write_frame();
    test_garbage_read();
    test_bad_checksum();
    test_bad_cmd();
    test_timeout();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
